// File: rtl/cacheline_adaptor.sv
// Bridges 256-bit cache line requests to four 64-bit memory beats; resp_o pulses one cycle after the 4th strobe.
// Beats advance only on resp_i, so memory may stall freely between beats; no combinational input-to-output paths.
module cacheline_adaptor (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] line_i,
  output logic [255:0] line_o,
  input  logic [31:0]  address_i,
  input  logic         read_i,
  input  logic         write_i,
  output logic         resp_o,
  input  logic [63:0]  burst_i,
  output logic [63:0]  burst_o,
  output logic [31:0]  address_o,
  output logic         read_o,
  output logic         write_o,
  input  logic         resp_i
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

  state_e       state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [31:0]  addr_q, addr_d;
  logic [255:0] wline_q, wline_d;
  logic [255:0] rbuf_q, rbuf_d;
  logic [7:0]   lsb;

  assign lsb = {cnt_q, 6'd0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      addr_q  <= 32'd0;
      wline_q <= 256'd0;
      rbuf_q  <= 256'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wline_q <= wline_d;
      rbuf_q  <= rbuf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wline_d = wline_q;
    rbuf_d  = rbuf_q;
    case (state_q)
      IDLE: begin
        if (read_i) begin
          addr_d  = address_i;
          cnt_d   = 2'd0;
          state_d = READ;
        end else if (write_i) begin
          addr_d  = address_i;
          wline_d = line_i;
          cnt_d   = 2'd0;
          state_d = WRITE;
        end
      end
      READ: begin
        if (resp_i) begin
          rbuf_d[lsb +: 64] = burst_i;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = DONE;
        end
      end
      WRITE: begin
        if (resp_i) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign line_o    = rbuf_q;
  assign address_o = {addr_q[31:5], 5'b0};
  assign read_o    = (state_q == READ);
  assign write_o   = (state_q == WRITE);
  assign resp_o    = (state_q == DONE);
  assign burst_o   = (state_q == WRITE) ? wline_q[lsb +: 64] : 64'h0;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor: table of line transactions plus reset and idle-strobe sequences.
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] line_i, line_o;
  logic [31:0]  address_i, address_o;
  logic         read_i, write_i, resp_o, read_o, write_o, resp_i;
  logic [63:0]  burst_i, burst_o;

  int n_cmp  = 0;
  int n_fail = 0;

  cacheline_adaptor dut (
    .clk(clk), .rst(rst),
    .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
    .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rd;
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] wline;
    logic [255:0] rline;
    logic [15:0]  strb;   // resp_i per burst cycle, LSB first
  } vec_t;

  typedef struct {
    logic [31:0]  addr;
    logic [255:0] line;
  } exp_t;

  vec_t         tbl [6];
  exp_t         sbq [$];
  logic [255:0] last_rd;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_txn(input vec_t v);
    exp_t e, got;
    int   k, c;
    e.addr = {v.addr[31:5], 5'b0};
    e.line = v.rd ? v.rline : last_rd;
    sbq.push_back(e);
    read_i = v.rd; write_i = v.wr; address_i = v.addr; line_i = v.wline; resp_i = 1'b0;
    step();
    address_i = ~v.addr;
    line_i    = ~v.wline;
    k = 0;
    c = 0;
    while (k < 4 && c < 16) begin
      resp_i  = v.strb[c];
      burst_i = v.rline[64*k +: 64];
      check("read_o in burst", read_o, v.rd);
      check("write_o in burst", write_o, v.wr & ~v.rd);
      check("burst_o beat", burst_o, v.rd ? 64'h0 : v.wline[64*k +: 64]);
      check("address_o hold", address_o, e.addr);
      check("resp_o early", resp_o, 1'b0);
      step();
      if (v.strb[c]) k++;
      c++;
    end
    resp_i  = 1'b0;
    burst_i = 64'h0;
    if (k < 4) check("beat budget", k, 4);
    check("resp_o pulse", resp_o, 1'b1);
    check("read_o in done", read_o, 1'b0);
    check("write_o in done", write_o, 1'b0);
    if (sbq.size() == 0) begin
      check("scoreboard empty", 1'b1, 1'b0);
    end else begin
      got = sbq.pop_front();
      check("line_o at done", line_o, got.line);
      check("address_o at done", address_o, got.addr);
    end
    read_i  = 1'b0;
    write_i = 1'b0;
    step();
    check("resp_o one cycle", resp_o, 1'b0);
    check("idle read_o", read_o, 1'b0);
    check("idle write_o", write_o, 1'b0);
    check("idle burst_o", burst_o, 64'h0);
    if (v.rd) last_rd = v.rline;
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 32'h1234_5678, 256'h0,
               {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 16'h000F};
    tbl[1] = '{1'b0, 1'b1, 32'h0000_2000,
               {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                64'h0F1E_2D3C_4B5A_6978, 64'h8796_A5B4_C3D2_E1F0}, 256'h0, 16'h002D};
    tbl[2] = '{1'b1, 1'b1, 32'h0000_0040, {4{64'hDEAD_BEEF_0000_0001}},
               {64'hA4A4_A4A4_A4A4_A4A4, 64'hA3A3_A3A3_A3A3_A3A3,
                64'hA2A2_A2A2_A2A2_A2A2, 64'hA1A1_A1A1_A1A1_A1A1}, 16'h000F};
    tbl[3] = '{1'b0, 1'b1, 32'hABCD_0013,
               {64'h1000_0000_0000_0004, 64'h1000_0000_0000_0003,
                64'h1000_0000_0000_0002, 64'h1000_0000_0000_0001}, 256'h0, 16'h000F};
    tbl[4] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 256'h0,
               {64'hC0DE_0000_0000_0004, 64'hC0DE_0000_0000_0003,
                64'hC0DE_0000_0000_0002, 64'hC0DE_0000_0000_0001}, 16'h0155};
    tbl[5] = '{1'b1, 1'b0, 32'h0000_1020, 256'h0,
               {64'h5555_0000_0000_0004, 64'h5555_0000_0000_0003,
                64'h5555_0000_0000_0002, 64'h5555_0000_0000_0001}, 16'h001E};

    rst = 1'b1;
    line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
    resp_i = 1'b0; burst_i = '0;
    last_rd = '0;
    step();
    step();
    check("reset read_o", read_o, 1'b0);
    check("reset write_o", write_o, 1'b0);
    check("reset resp_o", resp_o, 1'b0);
    check("reset address_o", address_o, 32'h0);
    check("reset burst_o", burst_o, 64'h0);
    check("reset line_o", line_o, 256'h0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 3; i++) do_txn(tbl[i]);

    resp_i  = 1'b1;
    burst_i = 64'hBAD0_BAD0_BAD0_BAD0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle strobe read_o", read_o, 1'b0);
      check("idle strobe write_o", write_o, 1'b0);
      check("idle strobe resp_o", resp_o, 1'b0);
      check("idle strobe line_o", line_o, last_rd);
    end
    resp_i = 1'b0;

    for (int i = 3; i < 5; i++) do_txn(tbl[i]);

    read_i = 1'b1; address_i = 32'h0000_3000;
    step();
    resp_i = 1'b1; burst_i = 64'hEEEE_EEEE_EEEE_EEEE;
    step();
    burst_i = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    resp_i = 1'b0; read_i = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("midburst rst read_o", read_o, 1'b0);
    check("midburst rst address_o", address_o, 32'h0);
    check("midburst rst line_o", line_o, 256'h0);
    check("midburst rst resp_o", resp_o, 1'b0);
    step();
    check("held rst resp_o", resp_o, 1'b0);
    rst = 1'b0;
    last_rd = '0;
    step();
    check("post rst resp_o", resp_o, 1'b0);
    do_txn(tbl[5]);
    check("scoreboard drained", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cacheline_adaptor.md
CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
- REQ-001: The block SHALL use one clock and an asynchronous, active-high reset, on ports named clk and rst.
- REQ-002: clk  input  1  rising-edge clock.
- REQ-003: rst  input  1  async active-high reset.
- REQ-004: line_i  input  256  write line from cache (pmem_wdata side).
- REQ-005: line_o  output  256  read line to cache (pmem_rdata side).
- REQ-006: address_i  input  32  line request address from cache.
- REQ-007: read_i  input  1  line read request, held until resp_o.
- REQ-008: write_i  input  1  line write request, held until resp_o.
- REQ-009: resp_o  output  1  line transfer complete, one-cycle pulse.
- REQ-010: burst_i  input  64  read beat from memory.
- REQ-011: burst_o  output  64  write beat to memory.
- REQ-012: address_o  output  32  line-aligned burst address to memory.
- REQ-013: read_o  output  1  burst read request.
- REQ-014: write_o  output  1  burst write request.
- REQ-015: resp_i  input  1  memory beat strobe: one beat transferred per cycle it is high.

Function
- REQ-016: The FSM SHALL have exactly four states: IDLE, READ, WRITE and DONE; a 2-bit beat counter SHALL count 0..3.
- REQ-017: In IDLE with read_i=1, the block SHALL latch address_i, clear the counter and go to READ next cycle.
- REQ-018: In IDLE with write_i=1 and read_i=0, the block SHALL latch address_i and line_i, clear the counter and go to WRITE.
- REQ-019: If read_i and write_i are both high in IDLE, read SHALL win.
- REQ-020: address_o SHALL be {latched_addr[31:5], 5'b0}, registered, and stable for the whole burst.
- REQ-021: read_o SHALL be 1 iff state=READ; write_o SHALL be 1 iff state=WRITE; both are driven from registered state with no combinational path from inputs.
- REQ-022: In READ, on each cycle with resp_i=1, the block SHALL write burst_i into buffer bits [64*count+63 : 64*count] and increment count.
- REQ-023: When the beat at count=3 is captured in READ, the block SHALL go to DONE.
- REQ-024: In WRITE, burst_o SHALL equal latched_line[64*count+63 : 64*count]; each resp_i=1 cycle SHALL increment count, and the beat at count=3 SHALL go to DONE.
- REQ-025: burst_o outside WRITE SHALL be 64'h0.
- REQ-026: resp_i=0 cycles inside a burst SHALL stall the counter; gaps between beats are legal.
- REQ-027: resp_i in IDLE or DONE SHALL be ignored.
- REQ-028: DONE SHALL assert resp_o for exactly one cycle, then go to IDLE unconditionally; read_i/write_i are not sampled in DONE.
- REQ-029: line_o SHALL drive the read buffer and hold its value from DONE until the next READ captures a beat; a write SHALL not modify it.
- REQ-030: Read latency: if the first resp_i cycle is M and beats are back-to-back, resp_o SHALL be high in cycle M+4.
- REQ-031: The requester drops its request in the cycle after resp_o; since IDLE follows DONE, no duplicate transfer SHALL occur.

Reset
- REQ-032: On rst=1, asynchronously: state=IDLE, count=0, read_o=0, write_o=0, resp_o=0, address_o=0, burst_o=0, line_o=0, latched line=0.
- REQ-033: A reset during a burst SHALL abandon the burst with no resp_o; after reset, operation SHALL restart from IDLE on the first clk edge with rst=0.

Verification
- REQ-034: Read, address_i=0x1234_5678, beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 back-to-back -> address_o=0x1234_5660; line_o={0x44..,0x33..,0x22..,0x11..}; resp_o one cycle, 4 cycles after first beat.
- REQ-035: Write, line_i=256'h0123...CDEF (4 distinct words), resp_i 1,0,1,1,0,1 -> burst_o steps word0..word3 only on resp_i cycles; write_o drops and resp_o pulses after the 4th strobe.
- REQ-036: read_i and write_i both high, address 0x40 -> read_o=1, write_o=0, address_o=0x40.
- REQ-037: rst raised after 2 read beats -> outputs zero immediately, no resp_o; next read completes correctly with count restarting at 0.
- REQ-038: resp_i pulsed in IDLE, then write then read -> no state change in IDLE; line_o unchanged by the write; the read updates line_o.
